// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: parametrised RPN integer calculator with an internal stack,
// a multi-cycle restoring divider for DIV/MOD and sticky per-cause error flags.
module rpn_stack_calc #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          apply,
  input  logic [W-1:0]  in,
  input  logic [2:0]    op,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          busy,
  output logic [2:0]    err,
  output logic          valid
);

  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_MOD  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_stack [DEPTH];
  logic [DW-1:0] r_depth;
  logic [W-1:0]  r_top;
  logic          r_empty;
  logic          r_full;
  logic [2:0]    r_err;
  logic          r_valid;

  logic [W-1:0]  r_dvsr;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_is_mod;

  logic          w_accept;
  logic          w_div_step;
  logic          w_div_done;
  logic          w_div_start;

  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_mul;
  logic          w_is_full;
  logic          w_is_empty;
  logic          w_has_two;

  logic          w_push;
  logic [W-1:0]  w_push_val;
  logic [1:0]    w_pop_n;
  logic [2:0]    w_err_set;
  logic [DW-1:0] w_depth_nxt;
  logic [DW-1:0] w_wr_idx;
  logic [W-1:0]  w_top_nxt;

  logic [W:0]    w_rem_sh;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quot_nxt;
  logic [W-1:0]  w_div_res;

  assign top   = r_top;
  assign depth = r_depth;
  assign empty = r_empty;
  assign full  = r_full;
  assign err   = r_err;
  assign valid = r_valid;
  assign busy  = (r_state == S_DIV);

  assign w_is_full  = (r_depth == DW'(DEPTH));
  assign w_is_empty = (r_depth == '0);
  assign w_has_two  = (r_depth >= DW'(2));
  assign w_mul      = w_a * w_b;

  // FSM state register: a reset mid-division aborts the divider
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: run for W iteration edges after a divide is accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == CW'(W - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: accept window, divider iteration and final-iteration strobe
  always_comb begin
    w_accept   = 1'b0;
    w_div_step = 1'b0;
    w_div_done = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = apply;
      S_DIV: begin
        w_div_step = 1'b1;
        w_div_done = (r_cnt == CW'(W - 1));
      end
      default: ;
    endcase
  end

  // Operand read: A is entry depth-1, B is entry depth-2 (no match when absent)
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == r_depth - DW'(1)) w_a = r_stack[i];
      if (DW'(i) == r_depth - DW'(2)) w_b = r_stack[i];
    end
  end

  // One restoring-division iteration; final result taken from the next values
  always_comb begin
    w_rem_sh   = {r_rem, r_quot[W-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    w_rem_nxt  = w_ge ? W'(w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh[W-1:0];
    w_quot_nxt = {r_quot[W-2:0], w_ge};
    w_div_res  = r_is_mod ? w_rem_nxt : w_quot_nxt;
  end

  // Op decode: error checks first, then pop count and optional push
  always_comb begin
    w_push      = 1'b0;
    w_push_val  = '0;
    w_pop_n     = 2'd0;
    w_err_set   = 3'b000;
    w_div_start = 1'b0;
    if (w_div_done) begin
      w_push     = 1'b1;
      w_push_val = w_div_res;
    end else if (w_accept) begin
      case (op)
        OP_PUSH: begin
          if (w_is_full) w_err_set[2] = 1'b1;
          else begin
            w_push     = 1'b1;
            w_push_val = in;
          end
        end
        OP_POP: begin
          if (w_is_empty) w_err_set[1] = 1'b1;
          else            w_pop_n      = 2'd1;
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (!w_has_two) w_err_set[1] = 1'b1;
          else begin
            w_pop_n = 2'd2;
            w_push  = 1'b1;
            if (op == OP_ADD)      w_push_val = w_b + w_a;
            else if (op == OP_SUB) w_push_val = w_b - w_a;
            else                   w_push_val = w_mul;
          end
        end
        OP_DIV, OP_MOD: begin
          if (!w_has_two)      w_err_set[1] = 1'b1;
          else if (w_a == '0)  w_err_set[0] = 1'b1;
          else begin
            w_pop_n     = 2'd2;
            w_div_start = 1'b1;
          end
        end
        OP_DUP: begin
          if (w_is_empty)     w_err_set[1] = 1'b1;
          else if (w_is_full) w_err_set[2] = 1'b1;
          else begin
            w_push     = 1'b1;
            w_push_val = w_a;
          end
        end
        default: ;
      endcase
    end
  end

  // Next depth, write slot and next top-of-stack value
  always_comb begin
    w_wr_idx    = r_depth - DW'(w_pop_n);
    w_depth_nxt = w_wr_idx + DW'(w_push);
    w_top_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == w_depth_nxt - DW'(1)) w_top_nxt = r_stack[i];
    end
    if (w_push) w_top_nxt = w_push_val;
  end

  // Stack storage and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_depth <= '0;
      r_top   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_err   <= 3'b000;
      r_valid <= 1'b1;
    end else begin
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (DW'(i) == w_wr_idx) r_stack[i] <= w_push_val;
        end
      end
      r_depth <= w_depth_nxt;
      r_top   <= w_top_nxt;
      r_empty <= (w_depth_nxt == '0);
      r_full  <= (w_depth_nxt == DW'(DEPTH));
      r_err   <= r_err | w_err_set;
      r_valid <= ((r_err | w_err_set) == 3'b000);
    end
  end

  // Divider datapath: latch B as dividend and A as divisor, then iterate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvsr   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_is_mod <= 1'b0;
    end else if (w_div_start) begin
      r_dvsr   <= w_a;
      r_quot   <= w_b;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_is_mod <= (op == OP_MOD);
    end else if (w_div_step) begin
      r_quot <= w_quot_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: directed vector table, hand-written multi-cycle
// sequences and random ops checked against a queue-based reference model.
module tb_rpn_stack_calc;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam int unsigned MASK  = (1 << W) - 1;

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         MUL  = 3'd4, DIV = 3'd5, MOD = 3'd6, DUP = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          apply;
  logic [W-1:0]  in;
  logic [2:0]    op;
  logic [W-1:0]  top;
  logic [DW-1:0] depth;
  logic          empty;
  logic          full;
  logic          busy;
  logic [2:0]    err;
  logic          valid;

  always #5 clk = ~clk;

  rpn_stack_calc #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .apply(apply), .in(in), .op(op),
    .top(top), .depth(depth), .empty(empty), .full(full),
    .busy(busy), .err(err), .valid(valid)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int unsigned ms[$];
  logic [2:0]  merr;
  bit          mbusy;
  bit          m_pend;
  int unsigned m_res;

  typedef struct {
    bit          do_rst;
    logic [2:0]  op;
    logic [W-1:0] v;
    int unsigned etop;
    int unsigned edepth;
    logic [2:0]  eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void tv(bit r, logic [2:0] o, logic [W-1:0] v,
                             int unsigned t, int unsigned d, logic [2:0] e);
    vec_t x;
    x.do_rst = r; x.op = o; x.v = v; x.etop = t; x.edepth = d; x.eerr = e;
    tbl.push_back(x);
  endfunction

  // Model: apply one op to the abstract stack; divides report a pending result
  function automatic void m_apply(logic [2:0] o, logic [W-1:0] v);
    int unsigned n, a, b, r;
    n = ms.size();
    m_pend = 1'b0;
    case (o)
      PUSH: if (n == DEPTH) merr[2] = 1'b1; else ms.push_back(int'(v));
      POP:  if (n == 0) merr[1] = 1'b1; else void'(ms.pop_back());
      DUP: begin
        if (n == 0) merr[1] = 1'b1;
        else if (n == DEPTH) merr[2] = 1'b1;
        else ms.push_back(ms[n-1]);
      end
      default: begin
        if (n < 2) merr[1] = 1'b1;
        else begin
          a = ms[n-1];
          b = ms[n-2];
          if ((o == DIV || o == MOD) && a == 0) merr[0] = 1'b1;
          else begin
            void'(ms.pop_back());
            void'(ms.pop_back());
            case (o)
              ADD:     r = (b + a) & MASK;
              SUB:     r = (b - a) & MASK;
              MUL:     r = (b * a) & MASK;
              DIV:     r = b / a;
              default: r = b % a;
            endcase
            if (o == DIV || o == MOD) begin
              m_pend = 1'b1;
              m_res  = r;
            end else ms.push_back(r);
          end
        end
      end
    endcase
  endfunction

  task automatic check_state(string tag);
    int unsigned et;
    et = (ms.size() > 0) ? ms[ms.size()-1] : 0;
    chk({tag, " top"},   top,   et);
    chk({tag, " depth"}, depth, ms.size());
    chk({tag, " empty"}, empty, ms.size() == 0);
    chk({tag, " full"},  full,  ms.size() == DEPTH);
    chk({tag, " busy"},  busy,  mbusy);
    chk({tag, " err"},   err,   merr);
    chk({tag, " valid"}, valid, merr == 3'b000);
  endtask

  task automatic drive(logic [2:0] o, logic [W-1:0] v);
    op = o; in = v; apply = 1'b1;
    @(negedge clk);
    apply = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; apply = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ms.delete(); merr = 3'b000; mbusy = 1'b0;
    check_state("reset");
  endtask

  // Apply one op and, for DIV/MOD, follow the busy window edge by edge
  task automatic run_op(logic [2:0] o, logic [W-1:0] v, bit noise);
    m_apply(o, v);
    mbusy = m_pend;
    drive(o, v);
    check_state("op");
    if (m_pend) begin
      for (int k = 1; k <= W; k++) begin
        if (noise) begin
          apply = 1'($urandom_range(0, 1));
          op    = 3'($urandom);
          in    = W'($urandom);
        end
        @(negedge clk);
        apply = 1'b0;
        if (k == W) begin
          mbusy = 1'b0;
          ms.push_back(m_res);
        end
        check_state("div");
      end
    end
  endtask

  initial begin
    rst = 1'b1; apply = 1'b0; op = 3'd0; in = '0;
    merr = 3'b000; mbusy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_state("init");

    // directed table: {reset-before, op, in, top, depth, err}
    tv(1, PUSH, 20, 20, 1, 3'b000);
    tv(0, PUSH, 3, 3, 2, 3'b000);
    tv(0, DIV, 0, 6, 1, 3'b000);
    tv(0, PUSH, 20, 20, 2, 3'b000);
    tv(0, PUSH, 3, 3, 3, 3'b000);
    tv(0, MOD, 0, 2, 2, 3'b000);
    tv(1, PUSH, 200, 200, 1, 3'b000);
    tv(0, PUSH, 100, 100, 2, 3'b000);
    tv(0, ADD, 0, 44, 1, 3'b000);
    tv(0, PUSH, 5, 5, 2, 3'b000);
    tv(0, SUB, 0, 39, 1, 3'b000);
    tv(0, PUSH, 3, 3, 2, 3'b000);
    tv(0, PUSH, 5, 5, 3, 3'b000);
    tv(0, SUB, 0, 254, 2, 3'b000);
    tv(0, PUSH, 16, 16, 3, 3'b000);
    tv(0, PUSH, 17, 17, 4, 3'b000);
    tv(0, MUL, 0, 16, 3, 3'b000);
    tv(1, PUSH, 5, 5, 1, 3'b000);
    tv(0, PUSH, 0, 0, 2, 3'b000);
    tv(0, DIV, 0, 0, 2, 3'b001);
    tv(0, PUSH, 7, 7, 3, 3'b001);
    tv(1, PUSH, 1, 1, 1, 3'b000);
    tv(0, PUSH, 2, 2, 2, 3'b000);
    tv(0, PUSH, 3, 3, 3, 3'b000);
    tv(0, PUSH, 4, 4, 4, 3'b000);
    tv(0, PUSH, 9, 4, 4, 3'b100);
    tv(1, PUSH, 1, 1, 1, 3'b000);
    tv(0, ADD, 0, 1, 1, 3'b010);
    tv(0, DUP, 0, 1, 2, 3'b010);
    tv(0, DUP, 0, 1, 3, 3'b010);
    tv(0, DUP, 0, 1, 4, 3'b010);
    tv(0, DUP, 0, 1, 4, 3'b110);
    tv(0, POP, 0, 1, 3, 3'b110);
    tv(1, POP, 0, 0, 0, 3'b010);
    tv(1, PUSH, 0, 0, 1, 3'b000);
    tv(0, MOD, 0, 0, 1, 3'b010);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      run_op(tbl[i].op, tbl[i].v, 1'b0);
      chk("tbl top",   top,   tbl[i].etop);
      chk("tbl depth", depth, tbl[i].edepth);
      chk("tbl err",   err,   tbl[i].eerr);
    end

    // reset during the third busy cycle aborts the divide with no late push
    do_reset();
    run_op(PUSH, 100, 1'b0);
    run_op(PUSH, 7, 1'b0);
    drive(DIV, 0);
    chk("abort busy0", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy",  busy,  0);
    chk("abort depth", depth, 0);
    chk("abort empty", empty, 1);
    chk("abort err",   err,   0);
    repeat (W + 2) @(negedge clk);
    chk("abort late depth", depth, 0);
    chk("abort late busy",  busy,  0);
    chk("abort late top",   top,   0);

    // reset wins over an apply in the same cycle
    rst = 1'b1; op = PUSH; in = 77; apply = 1'b1;
    @(negedge clk);
    rst = 1'b0; apply = 1'b0;
    chk("rst+apply depth", depth, 0);
    chk("rst+apply top",   top,   0);

    // apply while busy is ignored and the result lands on schedule
    do_reset();
    run_op(PUSH, 20, 1'b0);
    run_op(PUSH, 3, 1'b0);
    drive(DIV, 0);
    drive(PUSH, 55);
    chk("ignore busy",  busy,  1);
    chk("ignore depth", depth, 0);
    chk("ignore top",   top,   0);
    chk("ignore err",   err,   0);
    repeat (W - 2) @(negedge clk);
    chk("ignore busy last", busy, 1);
    @(negedge clk);
    chk("ignore done busy",  busy,  0);
    chk("ignore done top",   top,   6);
    chk("ignore done depth", depth, 1);
    chk("ignore done err",   err,   0);

    // random ops against the reference model, with noise applies during busy
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] rv;
      if ($urandom_range(0, 49) == 0) do_reset();
      ro = ($urandom_range(0, 9) <= 3) ? PUSH : 3'($urandom_range(1, 7));
      rv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      run_op(ro, rv, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
Parametrised successor to the fixed 8-bit calculator core. It is a stack-based (RPN) integer calculator with configurable data width and stack depth. DIV and MOD run on a multi-cycle restoring divider behind a busy flag. Error reporting is split into sticky per-cause flags, adding overflow and underflow detection alongside divide-by-zero. The block sits between the operand/opcode front end and the result display; the stack storage is internal, with no separate queue instance.

Parameters:
W, 8, data width of operands, results and stack entries (W >= 2)
DEPTH, 8, number of stack entries (DEPTH >= 2)
DW, $clog2(DEPTH+1), width of the depth counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high; sampled on rising edge of clk
apply  input  1  execute op this cycle (single-cycle strobe)
in  input  W  operand for PUSH
op  input  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 MOD, 7 DUP
top  output  W  current top-of-stack entry; 0 when empty
depth  output  DW  number of valid entries
empty  output  1  depth == 0
full  output  1  depth == DEPTH
busy  output  1  divider running; apply ignored
err  output  3  sticky error flags: [0] divide-by-zero, [1] underflow, [2] overflow
valid  output  1  err == 0

Behaviour:
- Reset: clears depth to 0, top to 0, err to 0 and busy to 0; empty=1, full=0, valid=1. Reset has priority over everything, including an apply in the same cycle.
- Operand naming: A = top entry, B = entry below A.
- Binary ops pop A and B and push the result, so depth decreases by 1.
- Result order is B op A for every binary op: SUB = B-A, DIV = B/A, MOD = B%A.
- Arithmetic is unsigned and modulo 2^W:
  - ADD and SUB wrap.
  - MUL keeps the low W bits of the 2W-bit product.
  - DIV and MOD use the unsigned quotient and remainder.
- PUSH: pushes in, depth +1. POP: discards A, depth -1. DUP: pushes a copy of A, depth +1.
- Single-cycle ops (PUSH, POP, ADD, SUB, MUL, DUP): the stack updates on the edge where apply=1 is sampled. New top, depth, empty and full are visible right after that edge.
- DIV/MOD sequence:
  - On the apply edge: A and B are latched, both are popped (depth -2), and busy rises.
  - The divider then iterates one quotient bit per cycle for W cycles.
  - On the W-th edge after apply, the result is pushed (depth +1) and busy falls in the same update.
  - The result is visible after W edges.
  - While busy, top and depth reflect the popped stack.
- apply while busy=1: ignored silently. No state change, no error.
- Error checks are evaluated at the apply edge. On error, the stack is left unchanged, the op is not executed and the matching err bit sets:
  - Underflow (err[1]): binary op with depth < 2; POP or DUP with depth == 0.
  - Overflow (err[2]): PUSH or DUP with depth == DEPTH. Binary ops never overflow.
  - Divide-by-zero (err[0]): DIV or MOD with A == 0 and depth >= 2. The divider does not start and busy stays 0.
- Error precedence: underflow is checked before divide-by-zero, and only one flag sets per apply.
- err bits are sticky until rst. Later valid ops still execute normally.
- Reset mid-division aborts the divider with no push. After that edge: busy=0, depth=0.
- Depth counter never wraps. Storage is an array indexed by depth-1, with no pointer wrap.

Test Plan:
- W=8, DEPTH=4: PUSH 20, PUSH 3, DIV -> busy=1 for exactly 8 cycles, then top=6, depth=1, valid=1. Repeat with MOD -> top=2.
- PUSH 200, PUSH 100, ADD -> top=44; then PUSH 5, SUB -> top=39; PUSH 3, PUSH 5, SUB -> top=254; PUSH 16, PUSH 17, MUL -> top=16.
- PUSH 5, PUSH 0, DIV -> err=3'b001, valid=0, busy stays 0, depth=2, top=0. A following PUSH 7 executes (top=7, depth=3) and err stays 3'b001.
- PUSH 1, 2, 3, 4 (full=1), then PUSH 9 -> err[2]=1, top=4, depth=4. After rst: ADD with depth=1 -> err[1]=1, depth unchanged.
- PUSH 100, PUSH 7, DIV; assert rst on the 3rd busy cycle -> next edge busy=0, depth=0, empty=1, err=0. No late result push afterwards.
- During busy, apply PUSH 55 -> ignored: depth and top unchanged, err=0; the division result is pushed on schedule.
